// File: rtl/ahb_bridge_pkg.sv
// Shared types and helpers for the AHB-Lite to flat peripheral bus bridge.
// FSM state encoding, HTRANS/HSIZE codes, byte-lane strobe and transfer error decode.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [3:0] size_to_strobe(input logic [2:0] hsize, input logic [1:0] lane);
        logic [3:0] strb;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << lane;
            HSIZE_HALF: strb = 4'b0011 << {lane[1], 1'b0};
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Addresses are passed zero-extended to 64 bits so the helper is width-agnostic.
    function automatic logic is_err(input logic [2:0] hsize, input logic [63:0] addr,
                                    input logic [63:0] range);
        logic err;
        err = 1'b0;
        if (hsize > HSIZE_WORD)                              err = 1'b1;
        if ((hsize == HSIZE_HALF) && addr[0])                err = 1'b1;
        if ((hsize == HSIZE_WORD) && (addr[1:0] != 2'b00))   err = 1'b1;
        if (addr >= range)                                   err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/ahb_busif_bridge.sv
// Pipelined AHB-Lite subordinate driving the flat peripheral request bus; strobe issued in the data phase.
// Peripheral stall becomes AHB wait states. AHB_BRIDGE_ERR_RESP_EN enables the two-cycle ERROR response.
module ahb_busif_bridge
    import ahb_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_RANGE = 'h100
) (
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic                  hwrite_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic [31:0]           hwdata_i,
    input  logic                  hready_i,
    output logic [31:0]           hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [ADDR_WIDTH-1:0] busif_addr_o,
    output logic                  busif_wen_o,
    output logic                  busif_ren_o,
    output logic [31:0]           busif_wdata_o,
    output logic [3:0]            busif_strobe_o,
    input  logic [31:0]           busif_rdata_i,
    input  logic                  busif_stall_i
);

    state_e                r_state;
    state_e                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [3:0]            r_strobe;

    logic                  w_accept;
    logic                  w_err;
    logic                  w_load;
    logic [3:0]            w_strobe;
    state_e                w_err_state;

    assign w_accept = hsel_i & hready_i &
                      ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));
    assign w_err    = is_err(hsize_i, 64'(haddr_i), 64'(ADDR_RANGE));
    assign w_strobe = size_to_strobe(hsize_i, haddr_i[1:0]);

`ifdef AHB_BRIDGE_ERR_RESP_EN
    assign w_err_state = ST_ERR1;
`else
    // Without the ERROR response, a bad transfer takes a single OKAY drop cycle in ERR2.
    assign w_err_state = ST_ERR2;
`endif

    assign busif_addr_o = r_addr;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_strobe <= 4'b0000;
        end else if (w_load) begin
            r_addr   <= haddr_i;
            r_write  <= hwrite_i;
            r_strobe <= w_strobe;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        hreadyout_o    = 1'b1;
        hresp_o        = 1'b0;
        hrdata_o       = 32'h0;
        busif_wen_o    = 1'b0;
        busif_ren_o    = 1'b0;
        busif_wdata_o  = 32'h0;
        busif_strobe_o = 4'b0000;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
`ifdef AHB_BRIDGE_ERR_RESP_EN
                hresp_o = (r_state == ST_ERR2);
`endif
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_next_state = w_err ? w_err_state : ST_DATA;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                busif_wen_o    = r_write;
                busif_ren_o    = !r_write;
                busif_strobe_o = r_strobe;
                busif_wdata_o  = hwdata_i;
                hrdata_o       = busif_rdata_i;
                hreadyout_o    = !busif_stall_i;
                // Completing cycle doubles as the next address phase: zero-bubble pipelining.
                if (!busif_stall_i) begin
                    if (w_accept) begin
                        w_load       = 1'b1;
                        w_next_state = w_err ? w_err_state : ST_DATA;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_ERR1: begin
                hreadyout_o  = 1'b0;
`ifdef AHB_BRIDGE_ERR_RESP_EN
                hresp_o      = 1'b1;
`endif
                w_next_state = ST_ERR2;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_busif_bridge.sv
// Directed bench for ahb_busif_bridge: single/stalled/back-to-back transfers, lanes, errors, async reset.
// Build with AHB_BRIDGE_ERR_RESP_EN defined to check the ERROR response instead of the drop cycle.
module tb_ahb_busif_bridge;
    import ahb_bridge_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] busif_addr;
    logic        busif_wen;
    logic        busif_ren;
    logic [31:0] busif_wdata;
    logic [3:0]  busif_strobe;
    logic [31:0] busif_rdata;
    logic        busif_stall;

    int n_chk  = 0;
    int n_pass = 0;

    // Single subordinate on the bus: global HREADY is our own HREADYOUT.
    assign hready = hreadyout;

    ahb_busif_bridge #(.ADDR_WIDTH(32), .ADDR_RANGE(32'h0000_0100)) dut (
        .clk_i          (clk),
        .n_rst_i        (rst_n),
        .hsel_i         (hsel),
        .haddr_i        (haddr),
        .hwrite_i       (hwrite),
        .htrans_i       (htrans),
        .hsize_i        (hsize),
        .hwdata_i       (hwdata),
        .hready_i       (hready),
        .hrdata_o       (hrdata),
        .hreadyout_o    (hreadyout),
        .hresp_o        (hresp),
        .busif_addr_o   (busif_addr),
        .busif_wen_o    (busif_wen),
        .busif_ren_o    (busif_ren),
        .busif_wdata_o  (busif_wdata),
        .busif_strobe_o (busif_strobe),
        .busif_rdata_i  (busif_rdata),
        .busif_stall_i  (busif_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus_idle();
        hwdata      = 32'h0;
        busif_rdata = 32'h0;
        busif_stall = 1'b0;

        // Reset state
        #12;
        chk("rst_wen",    32'(busif_wen),    32'h0);
        chk("rst_ren",    32'(busif_ren),    32'h0);
        chk("rst_addr",   busif_addr,        32'h0);
        chk("rst_strobe", 32'(busif_strobe), 32'h0);
        chk("rst_hresp",  32'(hresp),        32'h0);
        chk("rst_hready", 32'(hreadyout),    32'h1);
        chk("rst_hrdata", hrdata,            32'h0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // BUSY transfer is never accepted
        hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
        next_cycle();
        bus_idle();
        @(negedge clk);
        chk("busy_wen", 32'(busif_wen), 32'h0);
        next_cycle();

        // Single write; HWDATA presented only in the data phase
        addr_phase(32'h10, 1'b1, HSIZE_WORD);
        hwdata = 32'h0;
        next_cycle();
        bus_idle();
        hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_wen",    32'(busif_wen),    32'h1);
        chk("wr_ren",    32'(busif_ren),    32'h0);
        chk("wr_addr",   busif_addr,        32'h10);
        chk("wr_strobe", 32'(busif_strobe), 32'hF);
        chk("wr_wdata",  busif_wdata,       32'hDEAD_BEEF);
        chk("wr_hready", 32'(hreadyout),    32'h1);
        next_cycle();
        @(negedge clk);
        chk("wr_done_wen", 32'(busif_wen), 32'h0);
        next_cycle();

        // Stalled read: three wait states, completes on the fourth cycle
        addr_phase(32'h04, 1'b0, HSIZE_WORD);
        busif_stall = 1'b1;
        busif_rdata = 32'h1234_5678;
        next_cycle();
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) busif_stall = 1'b0;
            @(negedge clk);
            chk($sformatf("st_ren%0d", i),  32'(busif_ren), 32'h1);
            chk($sformatf("st_addr%0d", i), busif_addr,     32'h04);
            chk($sformatf("st_rdy%0d", i),  32'(hreadyout), (i == 3) ? 32'h1 : 32'h0);
            next_cycle();
        end
        chk("st_hrdata_idle", hrdata, 32'h0);
        chk("st_ren_idle", 32'(busif_ren), 32'h0);

        // Back-to-back write 0x08 then read 0x0C
        addr_phase(32'h08, 1'b1, HSIZE_WORD);
        next_cycle();
        addr_phase(32'h0C, 1'b0, HSIZE_WORD);
        hwdata      = 32'hCAFE_F00D;
        busif_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("b2b_wen",   32'(busif_wen), 32'h1);
        chk("b2b_waddr", busif_addr,     32'h08);
        chk("b2b_wdata", busif_wdata,    32'hCAFE_F00D);
        next_cycle();
        bus_idle();
        @(negedge clk);
        chk("b2b_ren",    32'(busif_ren), 32'h1);
        chk("b2b_wen2",   32'(busif_wen), 32'h0);
        chk("b2b_raddr",  busif_addr,     32'h0C);
        chk("b2b_hrdata", hrdata,         32'hA5A5_5A5A);
        next_cycle();

        // Byte and half lanes
        addr_phase(32'h13, 1'b0, HSIZE_BYTE);
        next_cycle();
        addr_phase(32'h12, 1'b1, HSIZE_HALF);
        @(negedge clk);
        chk("byte13_strobe", 32'(busif_strobe), 32'h8);
        chk("byte13_ren",    32'(busif_ren),    32'h1);
        next_cycle();
        addr_phase(32'h21, 1'b1, HSIZE_BYTE);
        @(negedge clk);
        chk("half12_strobe", 32'(busif_strobe), 32'hC);
        next_cycle();
        bus_idle();
        @(negedge clk);
        chk("byte21_strobe", 32'(busif_strobe), 32'h2);
        next_cycle();

        // Error-flagged transfers: misaligned word, out of range, oversize
        busif_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: addr_phase(32'h02,  1'b1, HSIZE_WORD);
                1: addr_phase(32'h100, 1'b0, HSIZE_WORD);
                default: addr_phase(32'h40, 1'b1, 3'b011);
            endcase
            next_cycle();
            bus_idle();
            @(negedge clk);
            chk($sformatf("err%0d_wen", k), 32'(busif_wen), 32'h0);
            chk($sformatf("err%0d_ren", k), 32'(busif_ren), 32'h0);
`ifdef AHB_BRIDGE_ERR_RESP_EN
            chk($sformatf("err%0d_c1_rdy", k),  32'(hreadyout), 32'h0);
            chk($sformatf("err%0d_c1_resp", k), 32'(hresp),     32'h1);
            next_cycle();
            @(negedge clk);
            chk($sformatf("err%0d_c2_rdy", k),  32'(hreadyout), 32'h1);
            chk($sformatf("err%0d_c2_resp", k), 32'(hresp),     32'h1);
            chk($sformatf("err%0d_c2_wen", k),  32'(busif_wen), 32'h0);
`else
            chk($sformatf("err%0d_rdy", k),    32'(hreadyout), 32'h1);
            chk($sformatf("err%0d_resp", k),   32'(hresp),     32'h0);
            chk($sformatf("err%0d_hrdata", k), hrdata,         32'h0);
`endif
            next_cycle();
            @(negedge clk);
            chk($sformatf("err%0d_after_resp", k), 32'(hresp),     32'h0);
            chk($sformatf("err%0d_after_rdy", k),  32'(hreadyout), 32'h1);
            next_cycle();
        end

        // Async reset in a stalled data phase
        addr_phase(32'h20, 1'b1, HSIZE_WORD);
        busif_stall = 1'b1;
        next_cycle();
        bus_idle();
        @(negedge clk);
        chk("ar_pre_wen", 32'(busif_wen), 32'h1);
        chk("ar_pre_rdy", 32'(hreadyout), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wen",  32'(busif_wen), 32'h0);
        chk("ar_ren",  32'(busif_ren), 32'h0);
        chk("ar_rdy",  32'(hreadyout), 32'h1);
        next_cycle();
        rst_n       = 1'b1;
        busif_stall = 1'b0;
        next_cycle();
        addr_phase(32'h30, 1'b1, HSIZE_BYTE);
        next_cycle();
        bus_idle();
        hwdata = 32'h0000_0077;
        @(negedge clk);
        chk("ar_post_wen",    32'(busif_wen),    32'h1);
        chk("ar_post_addr",   busif_addr,        32'h30);
        chk("ar_post_strobe", 32'(busif_strobe), 32'h1);
        chk("ar_post_wdata",  busif_wdata,       32'h0000_0077);
        next_cycle();
        @(negedge clk);
        chk("ar_post_idle", 32'(busif_wen), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_busif_bridge.md
Name: ahb_busif_bridge

Overview:
- Pipelined AHB-Lite subordinate that drives the flat peripheral request/response bus into usbh_host (bus_protocol_if peripheral side); it sits directly upstream of the host controller.
- Address phase is registered and the peripheral strobe is issued in the AHB data phase. This aligns HWDATA with wen, honours peripheral stall as AHB wait states, and generates byte strobes from HSIZE/HADDR.
- Replaces the combinational AHB-to-bus hookup for SoC integration.

Parameters:
- ADDR_WIDTH, 32, width of HADDR and busif_addr_o.
- ADDR_RANGE, 32'h0000_0100, bytes decoded; offsets at or above this are out of range.

Ports:
- clk_i  in  1  single clock.
- n_rst_i  in  1  asynchronous, active-low reset.
- hsel_i  in  1  AHB select.
- haddr_i  in  ADDR_WIDTH  AHB address.
- hwrite_i  in  1  AHB write.
- htrans_i  in  2  AHB transfer type.
- hsize_i  in  3  AHB size.
- hwdata_i  in  32  AHB write data (data phase).
- hready_i  in  1  global HREADY.
- hrdata_o  out  32  read data.
- hreadyout_o  out  1  subordinate ready.
- hresp_o  out  1  0=OKAY, 1=ERROR.
- busif_addr_o  out  ADDR_WIDTH  registered address.
- busif_wen_o  out  1  write request.
- busif_ren_o  out  1  read request.
- busif_wdata_o  out  32  write data.
- busif_strobe_o  out  4  byte enables.
- busif_rdata_i  in  32  peripheral read data.
- busif_stall_i  in  1  peripheral request_stall.

Behaviour:
- Reset (async, n_rst_i=0): state IDLE; busif_wen_o=busif_ren_o=0; busif_addr_o=0; busif_strobe_o=0; hresp_o=0; hreadyout_o=1; hrdata_o=0.
- Address-phase accept: hsel_i & htrans_i[1] & hready_i on a rising edge.
  - Registers haddr, hwrite, hsize.
  - Computes strobe and the error flag.
  - Moves to DATA, or to ERR1 when the error flag is set.
- Ignored transfers: IDLE (00) and BUSY (01) are never accepted.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE:
  - Outputs are quiet, hreadyout_o=1.
  - Accept -> DATA or ERR1.
- DATA:
  - busif_wen_o = registered hwrite; busif_ren_o = !registered hwrite.
  - busif_wdata_o = hwdata_i (combinational); hrdata_o = busif_rdata_i (combinational).
  - hreadyout_o = !busif_stall_i.
  - While stalled, addr/strobe/wen/ren are held unchanged.
  - On the cycle with stall=0, the transfer completes. A new accept on that same edge goes directly to DATA or ERR1 with zero bubble; otherwise the state returns to IDLE.
- ERR1: hreadyout_o=0, hresp_o=1, no busif request -> ERR2.
- ERR2: hreadyout_o=1, hresp_o=1. An accept is honoured as in IDLE (AHB permits the master to cancel, but the next transfer is still sampled).
- Strobe generation (ADDR[1:0] gives the lane):
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
  - Reads also drive the strobe.
- Error flag is set by any of:
  - hsize_i > 3'b010;
  - misaligned address (half with addr[0]=1; word with addr[1:0]!=0);
  - haddr_i >= ADDR_RANGE.
- Data timing: write data is never sampled in the address phase; HWDATA is used only in DATA.
- Reset mid-transfer: requests drop immediately (async) and hreadyout_o returns to 1.

Optional Feature:
- Macro: AHB_BRIDGE_ERR_RESP_EN.
- Defined: error-flagged transfers take the ERR1/ERR2 two-cycle ERROR response; no busif strobe is issued.
- Undefined:
  - Error-flagged transfers go to a one-cycle DROP handling with hreadyout_o=1 and hresp_o=0.
  - No busif request is issued, writes are discarded, and hrdata_o=0.
  - hresp_o is tied to 0.

Decomposition:
- Shared package ahb_bridge_pkg holds:
  - state enum (IDLE, DATA, ERR1, ERR2);
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE constants (BYTE, HALF, WORD);
  - function size_to_strobe(hsize, addr[1:0]);
  - function is_err(hsize, addr).
- No sub-module; one FSM plus address-phase registers.

Test Plan:
1. Single write: NONSEQ write, haddr=0x10, word, hwdata=0xDEADBEEF, stall=0 -> next cycle wen=1, addr=0x10, strobe=1111, wdata=0xDEADBEEF, hreadyout=1.
2. Stalled read: read at 0x04 with stall held 3 cycles -> ren=1 and addr stable for 4 cycles, hreadyout=0 for 3 cycles, hrdata=busif_rdata on the completing cycle.
3. Back-to-back: write 0x08 then read 0x0C on consecutive NONSEQ cycles -> wen in cycle 2 and ren in cycle 3, no bubble.
4. Byte/half lanes:
   - byte at 0x13 -> strobe 1000;
   - half at 0x12 -> strobe 1100.
5. Error response (macro defined): word write at 0x02 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), wen never asserted. Macro undefined -> OKAY with no wen.
6. Async reset during a stalled DATA phase -> wen/ren=0 and hreadyout=1 without a clock edge; the next transfer after release completes normally.
